// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : ALU op codes, RV32I opcode constants and the decoded-control
//               record shared by the issue controller and its decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] c_ALU_AND   = 4'b0000;
    localparam logic [3:0] c_ALU_OR    = 4'b0001;
    localparam logic [3:0] c_ALU_SUM   = 4'b0010;
    localparam logic [3:0] c_ALU_EQUAL = 4'b0011;
    localparam logic [3:0] c_ALU_SLL   = 4'b0100;
    localparam logic [3:0] c_ALU_SRL   = 4'b0101;
    localparam logic [3:0] c_ALU_SRA   = 4'b0111;
    localparam logic [3:0] c_ALU_XOR   = 4'b1000;
    localparam logic [3:0] c_ALU_NOR   = 4'b1001;
    localparam logic [3:0] c_ALU_SUB   = 4'b1010;
    localparam logic [3:0] c_ALU_GE    = 4'b1100;
    localparam logic [3:0] c_ALU_GEU   = 4'b1101;
    localparam logic [3:0] c_ALU_SLT   = 4'b1110;
    localparam logic [3:0] c_ALU_SLTU  = 4'b1111;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] c_F7_ZERO = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       use_imm;
        logic       zero_rs1;
        logic       is_branch;
        logic       br_inv;
        logic       br_use_zr;
        logic       illegal;
    } dec_t;

    // Shared OP / OP-IMM funct3 mapping; alt selects SUB and SRA.
    function automatic logic [3:0] f3_to_alu_op(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = alt ? c_ALU_SUB : c_ALU_SUM;
            3'b001:  op = c_ALU_SLL;
            3'b010:  op = c_ALU_SLT;
            3'b011:  op = c_ALU_SLTU;
            3'b100:  op = c_ALU_XOR;
            3'b101:  op = alt ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  op = c_ALU_OR;
            default: op = c_ALU_AND;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Combinational map of opcode/funct3/funct7 to ALU control.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import alu_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output dec_t       o_dec
);

    logic w_f7_zero;
    logic w_f7_alt;
    dec_t w_dec;

    assign w_f7_zero = (i_funct7 == c_F7_ZERO);
    assign w_f7_alt  = (i_funct7 == c_F7_ALT);

    always_comb begin
        w_dec        = '0;
        w_dec.alu_op = c_ALU_AND;
        case (i_opcode)
            c_OPC_OP: begin
                w_dec.alu_op  = f3_to_alu_op(i_funct3, i_funct7[5]);
                w_dec.illegal = !(w_f7_zero ||
                                  (w_f7_alt && (i_funct3 == 3'b000 || i_funct3 == 3'b101)));
            end
            c_OPC_OP_IMM: begin
                w_dec.use_imm = 1'b1;
                // ADDI has no SUB form: funct7 bits belong to the immediate there.
                w_dec.alu_op  = (i_funct3 == 3'b000) ? c_ALU_SUM
                                                     : f3_to_alu_op(i_funct3, i_funct7[5]);
                if (i_funct3 == 3'b001)
                    w_dec.illegal = !w_f7_zero;
                else if (i_funct3 == 3'b101)
                    w_dec.illegal = !(w_f7_zero || w_f7_alt);
            end
            c_OPC_LUI: begin
                w_dec.alu_op   = c_ALU_SUM;
                w_dec.use_imm  = 1'b1;
                w_dec.zero_rs1 = 1'b1;
            end
            c_OPC_BRANCH: begin
                w_dec.is_branch = 1'b1;
                case (i_funct3)
                    3'b000: begin
                        w_dec.alu_op    = c_ALU_SUB;
                        w_dec.br_use_zr = 1'b1;
                    end
                    3'b001: begin
                        w_dec.alu_op    = c_ALU_SUB;
                        w_dec.br_use_zr = 1'b1;
                        w_dec.br_inv    = 1'b1;
                    end
                    3'b100:  w_dec.alu_op  = c_ALU_SLT;
                    3'b101:  w_dec.alu_op  = c_ALU_GE;
                    3'b110:  w_dec.alu_op  = c_ALU_SLTU;
                    3'b111:  w_dec.alu_op  = c_ALU_GEU;
                    default: w_dec.illegal = 1'b1;
                endcase
            end
            default: w_dec.illegal = 1'b1;
        endcase

        // Illegal encodings flow as a plain AND with no side effects.
        if (w_dec.illegal) begin
            w_dec         = '0;
            w_dec.alu_op  = c_ALU_AND;
            w_dec.illegal = 1'b1;
        end
    end

    assign o_dec = w_dec;

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Two-stage issue/result pipeline driving an external ALU and
//               returning writeback and branch outcome over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK_i,
    input  logic            RST_N_i,
    input  logic            IN_VALID_i,
    output logic            IN_READY_o,
    input  logic [6:0]      OPCODE_i,
    input  logic [2:0]      FUNCT3_i,
    input  logic [6:0]      FUNCT7_i,
    input  logic [4:0]      RD_ADDR_i,
    input  logic [XLEN-1:0] RS1_VAL_i,
    input  logic [XLEN-1:0] RS2_VAL_i,
    input  logic [XLEN-1:0] IMM_i,
    output logic [3:0]      ALU_OP_o,
    output logic [XLEN-1:0] ALU_RS1_o,
    output logic [XLEN-1:0] ALU_RS2_o,
    input  logic [XLEN-1:0] ALU_RD_i,
    input  logic            ALU_ZR_i,
    output logic            OUT_VALID_o,
    input  logic            OUT_READY_i,
    output logic            WB_EN_o,
    output logic [4:0]      WB_ADDR_o,
    output logic [XLEN-1:0] WB_DATA_o,
    output logic            BR_TAKEN_o,
    output logic            ILLEGAL_o
);

    dec_t w_dec;
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_accept;

    // Issue stage
    logic            s1_valid_q,     s1_valid_d;
    logic [3:0]      s1_op_q,        s1_op_d;
    logic [XLEN-1:0] s1_rs1_q,       s1_rs1_d;
    logic [XLEN-1:0] s1_rs2_q,       s1_rs2_d;
    logic [4:0]      s1_rd_q,        s1_rd_d;
    logic            s1_is_br_q,     s1_is_br_d;
    logic            s1_br_inv_q,    s1_br_inv_d;
    logic            s1_br_zr_q,     s1_br_zr_d;
    logic            s1_illegal_q,   s1_illegal_d;

    // Result stage
    logic            s2_valid_q,     s2_valid_d;
    logic            s2_wb_en_q,     s2_wb_en_d;
    logic [4:0]      s2_wb_addr_q,   s2_wb_addr_d;
    logic [XLEN-1:0] s2_wb_data_q,   s2_wb_data_d;
    logic            s2_br_taken_q,  s2_br_taken_d;
    logic            s2_illegal_q,   s2_illegal_d;

    alu_decoder u_dec (
        .i_opcode (OPCODE_i),
        .i_funct3 (FUNCT3_i),
        .i_funct7 (FUNCT7_i),
        .o_dec    (w_dec)
    );

    assign w_s2_adv   = !s2_valid_q || OUT_READY_i;
    assign w_s1_adv   = s1_valid_q && w_s2_adv;
    assign IN_READY_o = !s1_valid_q || w_s1_adv;
    assign w_accept   = IN_VALID_i && IN_READY_o;

    // Operand fields only change on accept so the ALU inputs hold while idle.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_op_d      = s1_op_q;
        s1_rs1_d     = s1_rs1_q;
        s1_rs2_d     = s1_rs2_q;
        s1_rd_d      = s1_rd_q;
        s1_is_br_d   = s1_is_br_q;
        s1_br_inv_d  = s1_br_inv_q;
        s1_br_zr_d   = s1_br_zr_q;
        s1_illegal_d = s1_illegal_q;
        if (w_s1_adv)
            s1_valid_d = 1'b0;
        if (w_accept) begin
            s1_valid_d   = 1'b1;
            s1_op_d      = w_dec.alu_op;
            s1_rs1_d     = w_dec.zero_rs1 ? '0 : RS1_VAL_i;
            s1_rs2_d     = w_dec.use_imm ? IMM_i : RS2_VAL_i;
            s1_rd_d      = RD_ADDR_i;
            s1_is_br_d   = w_dec.is_branch;
            s1_br_inv_d  = w_dec.br_inv;
            s1_br_zr_d   = w_dec.br_use_zr;
            s1_illegal_d = w_dec.illegal;
        end
    end

    always_comb begin
        s2_valid_d    = s2_valid_q;
        s2_wb_en_d    = s2_wb_en_q;
        s2_wb_addr_d  = s2_wb_addr_q;
        s2_wb_data_d  = s2_wb_data_q;
        s2_br_taken_d = s2_br_taken_q;
        s2_illegal_d  = s2_illegal_q;
        if (w_s2_adv) begin
            s2_valid_d    = s1_valid_q;
            s2_wb_en_d    = s1_valid_q && !s1_is_br_q && !s1_illegal_q && (s1_rd_q != 5'd0);
            s2_br_taken_d = s1_valid_q && s1_is_br_q &&
                            (s1_br_zr_q ? (ALU_ZR_i ^ s1_br_inv_q) : ALU_RD_i[0]);
            s2_illegal_d  = s1_valid_q && s1_illegal_q;
            if (s1_valid_q) begin
                s2_wb_addr_d = s1_rd_q;
                s2_wb_data_d = ALU_RD_i;
            end
        end
    end

    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            s1_valid_q    <= 1'b0;
            s1_op_q       <= c_ALU_AND;
            s1_rs1_q      <= '0;
            s1_rs2_q      <= '0;
            s1_rd_q       <= '0;
            s1_is_br_q    <= 1'b0;
            s1_br_inv_q   <= 1'b0;
            s1_br_zr_q    <= 1'b0;
            s1_illegal_q  <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_wb_en_q    <= 1'b0;
            s2_wb_addr_q  <= '0;
            s2_wb_data_q  <= '0;
            s2_br_taken_q <= 1'b0;
            s2_illegal_q  <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_op_q       <= s1_op_d;
            s1_rs1_q      <= s1_rs1_d;
            s1_rs2_q      <= s1_rs2_d;
            s1_rd_q       <= s1_rd_d;
            s1_is_br_q    <= s1_is_br_d;
            s1_br_inv_q   <= s1_br_inv_d;
            s1_br_zr_q    <= s1_br_zr_d;
            s1_illegal_q  <= s1_illegal_d;
            s2_valid_q    <= s2_valid_d;
            s2_wb_en_q    <= s2_wb_en_d;
            s2_wb_addr_q  <= s2_wb_addr_d;
            s2_wb_data_q  <= s2_wb_data_d;
            s2_br_taken_q <= s2_br_taken_d;
            s2_illegal_q  <= s2_illegal_d;
        end
    end

    assign ALU_OP_o    = s1_op_q;
    assign ALU_RS1_o   = s1_rs1_q;
    assign ALU_RS2_o   = s1_rs2_q;
    assign OUT_VALID_o = s2_valid_q;
    assign WB_EN_o     = s2_wb_en_q;
    assign WB_ADDR_o   = s2_wb_addr_q;
    assign WB_DATA_o   = s2_wb_data_q;
    assign BR_TAKEN_o  = s2_br_taken_q;
    assign ILLEGAL_o   = s2_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Directed and randomized bench for alu_issue_ctrl with an
//               external ALU model and an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] rs1, rs2, imm;
    logic [3:0]  alu_op;
    logic [31:0] alu_rs1, alu_rs2, alu_rd;
    logic        alu_zr;
    logic        out_valid, out_ready;
    logic        wb_en, br_taken, illegal;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    typedef struct {
        logic        wb_en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        chk_data;
        logic        taken;
        logic        illegal;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic last_acc;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.XLEN(32)) dut (
        .CLK_i       (clk),
        .RST_N_i     (rst_n),
        .IN_VALID_i  (in_valid),
        .IN_READY_o  (in_ready),
        .OPCODE_i    (opcode),
        .FUNCT3_i    (funct3),
        .FUNCT7_i    (funct7),
        .RD_ADDR_i   (rd),
        .RS1_VAL_i   (rs1),
        .RS2_VAL_i   (rs2),
        .IMM_i       (imm),
        .ALU_OP_o    (alu_op),
        .ALU_RS1_o   (alu_rs1),
        .ALU_RS2_o   (alu_rs2),
        .ALU_RD_i    (alu_rd),
        .ALU_ZR_i    (alu_zr),
        .OUT_VALID_o (out_valid),
        .OUT_READY_i (out_ready),
        .WB_EN_o     (wb_en),
        .WB_ADDR_o   (wb_addr),
        .WB_DATA_o   (wb_data),
        .BR_TAKEN_o  (br_taken),
        .ILLEGAL_o   (illegal)
    );

    // External ALU
    always_comb begin
        alu_rd = 32'h0;
        case (alu_op)
            4'b0000: alu_rd = alu_rs1 & alu_rs2;
            4'b0001: alu_rd = alu_rs1 | alu_rs2;
            4'b0010: alu_rd = alu_rs1 + alu_rs2;
            4'b0011: alu_rd = {31'b0, alu_rs1 == alu_rs2};
            4'b0100: alu_rd = alu_rs1 << alu_rs2[4:0];
            4'b0101: alu_rd = alu_rs1 >> alu_rs2[4:0];
            4'b0111: alu_rd = $signed(alu_rs1) >>> alu_rs2[4:0];
            4'b1000: alu_rd = alu_rs1 ^ alu_rs2;
            4'b1001: alu_rd = ~(alu_rs1 | alu_rs2);
            4'b1010: alu_rd = alu_rs1 - alu_rs2;
            4'b1100: alu_rd = {31'b0, $signed(alu_rs1) >= $signed(alu_rs2)};
            4'b1101: alu_rd = {31'b0, alu_rs1 >= alu_rs2};
            4'b1110: alu_rd = {31'b0, $signed(alu_rs1) < $signed(alu_rs2)};
            4'b1111: alu_rd = {31'b0, alu_rs1 < alu_rs2};
            default: alu_rd = 32'h0;
        endcase
    end
    assign alu_zr = (alu_rd == 32'h0);

    // Instruction-level RV32I semantics
    function automatic exp_t ref_exec(input logic [6:0] opc, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic [4:0] d,
                                      input logic [31:0] a, input logic [31:0] b_reg,
                                      input logic [31:0] im);
        exp_t e;
        logic legal, br, cond;
        logic [31:0] b, r;
        legal = 1'b0; br = 1'b0; cond = 1'b0; r = 32'h0;
        if (opc == OPC_OP || opc == OPC_OP_IMM) begin
            b = (opc == OPC_OP) ? b_reg : im;
            case (f3)
                3'd0: r = (opc == OPC_OP && f7[5]) ? a - b : a + b;
                3'd1: r = a << b[4:0];
                3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: begin
                    if (f7[5]) r = $signed(a) >>> b[4:0];
                    else       r = a >> b[4:0];
                end
                3'd6: r = a | b;
                default: r = a & b;
            endcase
            if (opc == OPC_OP)
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            else if (f3 == 3'd1)
                legal = (f7 == 7'h00);
            else if (f3 == 3'd5)
                legal = (f7 == 7'h00) || (f7 == 7'h20);
            else
                legal = 1'b1;
        end else if (opc == OPC_LUI) begin
            r = im;
            legal = 1'b1;
        end else if (opc == OPC_BRANCH) begin
            br = 1'b1;
            legal = (f3 != 3'd2) && (f3 != 3'd3);
            case (f3)
                3'd0: cond = (a == b_reg);
                3'd1: cond = (a != b_reg);
                3'd4: cond = ($signed(a) < $signed(b_reg));
                3'd5: cond = ($signed(a) >= $signed(b_reg));
                3'd6: cond = (a < b_reg);
                3'd7: cond = (a >= b_reg);
                default: cond = 1'b0;
            endcase
        end
        e.wb_en    = legal && !br && (d != 5'd0);
        e.addr     = d;
        e.data     = r;
        e.chk_data = legal && !br;
        e.taken    = legal && br && cond;
        e.illegal  = !legal;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: score the retiring result, record the accepted instruction.
    task automatic cycle();
        exp_t e;
        #1;
        last_acc = in_valid && in_ready;
        if (out_valid === 1'b1 && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_wb_en", {31'b0, wb_en}, {31'b0, e.wb_en});
                chk("sb_wb_addr", {27'b0, wb_addr}, {27'b0, e.addr});
                if (e.chk_data) chk("sb_wb_data", wb_data, e.data);
                chk("sb_br_taken", {31'b0, br_taken}, {31'b0, e.taken});
                chk("sb_illegal", {31'b0, illegal}, {31'b0, e.illegal});
            end
        end
        if (last_acc) sb.push_back(ref_exec(opcode, funct3, funct7, rd, rs1, rs2, imm));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [4:0] d, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] im);
        opcode = o; funct3 = f3; funct7 = f7; rd = d; rs1 = a; rs2 = b; imm = im;
    endtask

    task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] d, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im);
        set_instr(o, f3, f7, d, a, b, im);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();
        chk("accept", {31'b0, last_acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic rand_instr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 3)       opcode = OPC_OP;
        else if (sel < 6)  opcode = OPC_OP_IMM;
        else if (sel == 6) opcode = OPC_LUI;
        else if (sel < 9)  opcode = OPC_BRANCH;
        else               opcode = 7'($urandom);
        funct3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0, 1:    funct7 = 7'h00;
            2:       funct7 = 7'h20;
            default: funct7 = 7'($urandom);
        endcase
        rd  = 5'($urandom);
        rs1 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
        imm = ($urandom_range(0, 1) == 0) ? {{20{rs2[11]}}, rs2[11:0]} : $urandom;
    endtask

    initial begin
        int idx;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_instr(7'h0, 3'h0, 7'h0, 5'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk); @(negedge clk);

        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_alu_op", {28'b0, alu_op}, 32'd0);
        chk("rst_alu_rs1", alu_rs1, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_flags", {29'b0, wb_en, br_taken, illegal}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_rst", {31'b0, in_ready}, 32'd1);
        @(negedge clk);

        // ADD with one-edge latency
        issue(OPC_OP, 3'd0, 7'h00, 5'd3, 32'd5, 32'd7, 32'd0);
        chk("add_alu_op", {28'b0, alu_op}, 32'b0010);
        chk("add_alu_rs1", alu_rs1, 32'd5);
        chk("add_alu_rs2", alu_rs2, 32'd7);
        chk("add_not_yet_valid", {31'b0, out_valid}, 32'd0);
        cycle();
        chk("add_out_valid", {31'b0, out_valid}, 32'd1);
        chk("add_wb_en", {31'b0, wb_en}, 32'd1);
        chk("add_wb_addr", {27'b0, wb_addr}, 32'd3);
        chk("add_wb_data", wb_data, 32'd12);

        // SRAI and an illegal shift-immediate funct7
        issue(OPC_OP_IMM, 3'd5, 7'h20, 5'd4, 32'h8000_0000, 32'd0, 32'd4);
        chk("srai_alu_op", {28'b0, alu_op}, 32'b0111);
        cycle();
        chk("srai_wb_data", wb_data, 32'hF800_0000);
        issue(OPC_OP_IMM, 3'd5, 7'h01, 5'd4, 32'h8000_0000, 32'd0, 32'd4);
        chk("ill_alu_op", {28'b0, alu_op}, 32'b0000);
        cycle();
        chk("ill_flag", {31'b0, illegal}, 32'd1);
        chk("ill_wb_en", {31'b0, wb_en}, 32'd0);

        // Branches
        issue(OPC_BRANCH, 3'd1, 7'h00, 5'd0, 32'd9, 32'd9, 32'd0);
        chk("bne_alu_op", {28'b0, alu_op}, 32'b1010);
        cycle();
        chk("bne_taken", {31'b0, br_taken}, 32'd0);
        issue(OPC_BRANCH, 3'd6, 7'h00, 5'd7, 32'd1, 32'hFFFF_FFFF, 32'd0);
        chk("bltu_alu_op", {28'b0, alu_op}, 32'b1111);
        cycle();
        chk("bltu_taken", {31'b0, br_taken}, 32'd1);
        chk("bltu_wb_en", {31'b0, wb_en}, 32'd0);

        // rd=0 ADD and LUI
        issue(OPC_OP, 3'd0, 7'h00, 5'd0, 32'd1, 32'd2, 32'd0);
        cycle();
        chk("rd0_out_valid", {31'b0, out_valid}, 32'd1);
        chk("rd0_wb_en", {31'b0, wb_en}, 32'd0);
        issue(OPC_LUI, 3'd0, 7'h00, 5'd5, 32'hDEAD_BEEF, 32'd0, 32'h1234_5000);
        chk("lui_alu_rs1", alu_rs1, 32'd0);
        chk("lui_alu_rs2", alu_rs2, 32'h1234_5000);
        cycle();
        chk("lui_wb_data", wb_data, 32'h1234_5000);
        out_ready = 1'b1;
        for (int c = 0; c < 10 && sb.size() > 0; c++) cycle();

        // Backpressure: four ADDs, result side stalled for the first cycles
        idx = 0;
        for (int c = 0; c < 40 && (idx < 4 || sb.size() > 0); c++) begin
            out_ready = (c >= 4);
            in_valid  = (idx < 4);
            set_instr(OPC_OP, 3'd0, 7'h00, 5'(idx + 1), 32'(100 * idx + 1), 32'(idx + 2), 32'd0);
            #1;
            if (c == 2 || c == 3) begin
                chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
                chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
                chk("bp_wb_data_stable", wb_data, sb[0].data);
            end
            cycle();
            if (last_acc) idx++;
        end
        chk("bp_all_accepted", 32'(idx), 32'd4);
        chk("bp_all_retired", 32'(sb.size()), 32'd0);

        // Reset with a full pipe
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_instr(OPC_OP, 3'd0, 7'h00, 5'd9, 32'd3, 32'd4, 32'd0);
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst_alu_op", {28'b0, alu_op}, 32'd0);
        chk("mrst_alu_rs1", alu_rs1, 32'd0);
        chk("mrst_wb", {wb_data[30:0] | {26'b0, wb_addr}, wb_en}, 32'd0);
        sb.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(OPC_OP, 3'd0, 7'h20, 5'd6, 32'd50, 32'd8, 32'd0);
        chk("post_rst_alu_op", {28'b0, alu_op}, 32'b1010);
        chk("post_rst_not_valid", {31'b0, out_valid}, 32'd0);
        cycle();
        chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
        chk("post_rst_data", wb_data, 32'd42);

        // Randomized traffic against the reference model
        for (int c = 0; c < 500; c++) begin
            rand_instr();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() > 0; c++) cycle();
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
